uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver, the far end of the block's uart_tx. Oversamples the serial rx line and
//  recovers start + 8 data bits (LSB first) + optional parity + 1 stop bit.
//  Presents each byte on a valid/ready output holding register, with parity, framing
//  and overrun error flags. Sits between the board rx pin and the byte-stream consumer.
// PARAMETERS
//  OVERSAMPLE  16  sample_tick pulses per bit period; even, >= 4
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  reset_n      in   1  asynchronous, active-low reset
//  sample_tick  in   1  1-clk strobe at OVERSAMPLE x baud rate
//  rx           in   1  serial input, idle high, asynchronous to clk
//  parity_en    in   1  1 = parity bit expected after data bits
//  parity_odd   in   1  expected parity = ^data ^ parity_odd (0 = even)
//  out_valid    out  1  out_data/flags hold a byte not yet consumed
//  out_ready    in   1  consumer accepts byte when out_valid & out_ready
//  out_data     out  8  received byte
//  parity_err   out  1  received parity bit != expected; valid with out_valid
//  frame_err    out  1  stop bit sampled 0; valid with out_valid
//  overrun_err  out  1  1-clk pulse: a byte was dropped (holding register full)
//  busy         out  1  1 while in any state other than IDLE
// BEHAVIOUR
//  Reset: out_valid, parity_err, frame_err, overrun_err, busy = 0; out_data = 0;
//   synchroniser flops = 1; state = IDLE; counters = 0.
//  rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
//  Counters advance only on sample_tick. tick_cnt is $clog2(OVERSAMPLE) bits; bit_idx is 3 bits.
//  FSM (transitions occur only on a sample_tick cycle):
//   IDLE:      rx_s==0 -> START, tick_cnt=0.
//   START:     at tick OVERSAMPLE/2-1 (mid-bit), if rx_s==1 -> IDLE (glitch, no output).
//              Otherwise -> DATA, tick_cnt=0, bit_idx=0.
//   DATA:      at tick OVERSAMPLE-1, shift rx_s into bit bit_idx (LSB first).
//              After bit 7 -> PARITY if parity_en, else STOP.
//   PARITY:    at tick OVERSAMPLE-1, capture rx_s as the parity bit -> STOP.
//   STOP:      at tick OVERSAMPLE-1, sample the stop bit and complete the frame.
//              Stop bit 1 -> IDLE; stop bit 0 -> WAIT_HIGH.
//   WAIT_HIGH: stay until rx_s==1, then -> IDLE. Blocks false starts during a break.
//  parity_en/parity_odd are sampled at the START->DATA transition and held for the frame.
//  Frame completion: in the clk cycle after the stop sample, the byte and its flags are loaded
//   into the holding register and out_valid=1. parity_err=0 when parity is disabled.
//   A frame error still delivers the byte, with frame_err=1.
//  Handshake: out_data/flags are stable while out_valid=1 & out_ready=0.
//   On transfer, out_valid falls the next cycle.
//  Overrun: completion while out_valid=1 and no transfer in that cycle -> new byte dropped,
//   old byte kept, overrun_err pulses 1 clk.
//  Simultaneous transfer + completion: no overrun; new byte loads, out_valid stays 1.
//  Latency: out_valid rises 1 clk after the stop-bit mid-sample
//   (~9.5/10.5 bit periods after the start edge).
//  reset_n low mid-frame: immediate return to reset state; partial byte discarded.
// TESTING
//  1. OVERSAMPLE=16, parity off, send 0xA5 with out_ready=1
//     -> one out_valid pulse, out_data=0xA5, no error flags.
//  2. parity_en=1, parity_odd=0, send 0x07 with parity bit 1 -> out_data=0x07, parity_err=0.
//     Repeat with parity bit 0 -> parity_err=1.
//  3. Send 0x3C with stop bit forced 0, then hold rx low 3 bit periods
//     -> out_data=0x3C, frame_err=1. No second byte until rx returns high and a new start arrives.
//  4. out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, overrun_err pulses once.
//     Raise out_ready -> 0x11 consumed, out_valid=0.
//  5. rx low pulse of 4 sample_ticks (< OVERSAMPLE/2) -> no out_valid; busy returns to 0.
//  6. Assert reset_n=0 during bit 4 of 0xFF, release, send 0x5A
//     -> only 0x5A delivered; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised rx, oversampled mid-bit sampling, 8N1 with optional
// parity, and a valid/ready holding register carrying parity/framing/overrun flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sample_tick,
  input  logic       rx,
  input  logic       parity_en,
  input  logic       parity_odd,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rx_meta;
  logic            r_rx_s;
  logic [TW-1:0]   r_tick_cnt;
  logic [TW-1:0]   w_tick_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_nxt;
  logic [7:0]      r_shift;
  logic            r_par_en;
  logic            r_par_odd;
  logic            r_par_bit;
  logic            r_done;
  logic            r_done_ferr;
  logic            w_take_data;
  logic            w_take_par;
  logic            w_take_stop;
  logic            w_latch_cfg;
  logic            w_par_err;

  logic            r_out_valid;
  logic [7:0]      r_out_data;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_overrun;

  // Synchroniser resets to the idle-high line level so reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_take_data = 1'b0;
    w_take_par  = 1'b0;
    w_take_stop = 1'b0;
    w_latch_cfg = 1'b0;
    if (sample_tick) begin
      unique case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_nxt = S_START;
            w_tick_nxt  = '0;
          end
        end
        S_START: begin
          if (r_tick_cnt == TICK_MID) begin
            if (r_rx_s) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DATA;
              w_tick_nxt  = '0;
              w_bit_nxt   = '0;
              w_latch_cfg = 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == TICK_LAST) begin
            w_take_data = 1'b1;
            w_tick_nxt  = '0;
            if (r_bit_idx == 3'd7) begin
              w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end else begin
              w_bit_nxt = r_bit_idx + 1'b1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == TICK_LAST) begin
            w_take_par  = 1'b1;
            w_tick_nxt  = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == TICK_LAST) begin
            w_take_stop = 1'b1;
            w_tick_nxt  = '0;
            w_state_nxt = r_rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            w_tick_nxt = r_tick_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (r_rx_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_par_bit   <= 1'b0;
      r_done      <= 1'b0;
      r_done_ferr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_done     <= w_take_stop;
      if (w_latch_cfg) begin
        r_par_en  <= parity_en;
        r_par_odd <= parity_odd;
      end
      if (w_take_data) r_shift[r_bit_idx] <= r_rx_s;
      if (w_take_par)  r_par_bit <= r_rx_s;
      if (w_take_stop) r_done_ferr <= ~r_rx_s;
    end
  end

  assign w_par_err = r_par_en & (r_par_bit != (^r_shift ^ r_par_odd));

  // A completing frame loads unless the old byte is still held and not leaving this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (r_out_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_out_valid  <= 1'b1;
          r_out_data   <= r_shift;
          r_parity_err <= w_par_err;
          r_frame_err  <= r_done_ferr;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames scored through a queue, plus hand-written
// overrun, glitch and mid-frame reset sequences.
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int TICK_DIV = 3;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sample_tick = 1'b0;
  logic       rx;
  logic       parity_en;
  logic       parity_odd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .rx          (rx),
    .parity_en   (parity_en),
    .parity_odd  (parity_odd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int tick_div = 0;
  always @(posedge clk) begin
    tick_div    <= (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
    sample_tick <= (tick_div == TICK_DIV - 1);
  end

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       par_en;
    logic       par_odd;
    logic       flip_par;
    logic       stop_bit;
    logic [3:0] low_hold;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t sb[$];
  int   checks     = 0;
  int   errors     = 0;
  int   ovr_cnt    = 0;
  int   deliveries = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic po,
                            input logic flip, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit((^d) ^ po ^ flip);
    drive_bit(stop_b);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 4 * BIT_CLKS) begin
      step(1);
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (overrun_err) ovr_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h expected none at %0t", out_data, $time);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("parity_err", parity_err, e.perr);
          check("frame_err", frame_err, e.ferr);
          deliveries++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  vec_t vecs[7];
  int   base_dlv;
  int   base_ovr;

  initial begin
    vecs[0] = '{data: 8'hA5, par_en: 0, par_odd: 0, flip_par: 0, stop_bit: 1, low_hold: 0, exp_perr: 0, exp_ferr: 0};
    vecs[1] = '{data: 8'h07, par_en: 1, par_odd: 0, flip_par: 0, stop_bit: 1, low_hold: 0, exp_perr: 0, exp_ferr: 0};
    vecs[2] = '{data: 8'h07, par_en: 1, par_odd: 0, flip_par: 1, stop_bit: 1, low_hold: 0, exp_perr: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h3C, par_en: 0, par_odd: 0, flip_par: 0, stop_bit: 0, low_hold: 3, exp_perr: 0, exp_ferr: 1};
    vecs[4] = '{data: 8'hC3, par_en: 1, par_odd: 1, flip_par: 0, stop_bit: 1, low_hold: 0, exp_perr: 0, exp_ferr: 0};
    vecs[5] = '{data: 8'h00, par_en: 1, par_odd: 1, flip_par: 1, stop_bit: 1, low_hold: 0, exp_perr: 1, exp_ferr: 0};
    vecs[6] = '{data: 8'hFF, par_en: 0, par_odd: 1, flip_par: 0, stop_bit: 1, low_hold: 0, exp_perr: 0, exp_ferr: 0};

    reset_n    = 1'b0;
    rx         = 1'b1;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    out_ready  = 1'b1;
    step(5);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_parity_err", parity_err, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun_err", overrun_err, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
    step(BIT_CLKS);

    for (int i = 0; i < 7; i++) begin
      parity_en  = vecs[i].par_en;
      parity_odd = vecs[i].par_odd;
      sb.push_back('{data: vecs[i].data, perr: vecs[i].exp_perr, ferr: vecs[i].exp_ferr});
      send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_odd, vecs[i].flip_par, vecs[i].stop_bit);
      if (vecs[i].low_hold != 0) begin
        rx = 1'b0;
        step(int'(vecs[i].low_hold) * BIT_CLKS);
        check("busy_in_break", busy, 1);
      end
      drive_bit(1'b1);
      drive_bit(1'b1);
      wait_drain("vec_drain");
      check("vec_idle_busy", busy, 0);
    end
    check("vec_deliveries", deliveries, 7);

    // Overrun: second byte dropped while the first is held.
    parity_en = 1'b0;
    out_ready = 1'b0;
    base_ovr  = ovr_cnt;
    sb.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    check("ovr_valid_held", out_valid, 1);
    check("ovr_data_held", out_data, 8'h11);
    check("ovr_pulses", ovr_cnt - base_ovr, 1);
    out_ready = 1'b1;
    step(3);
    check("ovr_consumed_valid", out_valid, 0);
    check("ovr_queue_empty", sb.size(), 0);

    // Glitch: 4-tick low pulse must be rejected.
    base_dlv = deliveries;
    rx = 1'b0;
    step(4 * TICK_DIV);
    check("glitch_busy_high", busy, 1);
    rx = 1'b1;
    step(2 * BIT_CLKS);
    check("glitch_busy_low", busy, 0);
    check("glitch_no_byte", deliveries - base_dlv, 0);
    check("glitch_no_valid", out_valid, 0);

    // Reset during bit 4 of 0xFF, then a clean 0x5A.
    base_dlv = deliveries;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    rx = 1'b1;
    step(BIT_CLKS / 2);
    check("pre_reset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_data", out_data, 0);
    check("mid_reset_flags", {parity_err, frame_err, overrun_err}, 0);
    step(5);
    reset_n = 1'b1;
    step(2 * BIT_CLKS);
    sb.push_back('{data: 8'h5A, perr: 1'b0, ferr: 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_bit(1'b1);
    wait_drain("reset_drain");
    step(2 * BIT_CLKS);
    check("reset_only_5a", deliveries - base_dlv, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
